// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and frame constants for the MCP3204 SPI sampler
package adc_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

   localparam int SAMPLE_W           = 12;
   localparam int CMD_BITS           = 5;
   localparam int FIRST_DATA_EDGE    = 7;
   localparam int LAST_EDGE          = 18;
   localparam int SHIFT_HALF_PERIODS = 38;

   // Command word sent MSB first: start, single-ended, D2=0, D1, D0
   function automatic logic [CMD_BITS-1:0] build_cmd(input logic [1:0] ch);
      return {1'b1, 1'b1, 1'b0, ch};
   endfunction

endpackage

// File: rtl/adc_sclk_divider.sv
// rtl/adc_sclk_divider.sv - SCLK half-period divider, held at zero while clr_i is high
module adc_sclk_divider #(
   parameter int CLK_DIV = 250
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic half_tick_o
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign half_tick_o = !clr_i && (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || half_tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - MCP3204 SPI frame sequencer; ADC_SPI_SAMPLER_AVG_EN averages groups of 4 frames
module adc_spi_sampler import adc_pkg::*; #(
   parameter int CLK_DIV    = 250,
   parameter int SAMPLE_GAP = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [1:0]          channel,
   input  logic                miso,
   output logic                cs_n,
   output logic                sclk,
   output logic                mosi,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_valid,
   output logic                busy
);

   state_e                state_q, state_d;
   logic [5:0]            hp_q, hp_d;
   logic [7:0]            gap_q, gap_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic [CMD_BITS-1:0]   cmd_q, cmd_d;
   logic [SAMPLE_W-1:0]   shreg_q, shreg_d;
   logic [SAMPLE_W-1:0]   sample_q, sample_d;
   logic                  valid_q, valid_d;
   logic                  half_tick;
   logic [5:0]            next_hp;

`ifdef ADC_SPI_SAMPLER_AVG_EN
   logic [SAMPLE_W+1:0]   acc_q, acc_d;
   logic [1:0]            grp_q, grp_d;
   logic [SAMPLE_W+1:0]   avg_sum;
   assign avg_sum = acc_q + {2'b00, shreg_q};
`endif

   adc_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
      .clk_i       (clk),
      .rst_ni      (rst),
      .clr_i       (state_q == IDLE),
      .half_tick_o (half_tick)
   );

   assign next_hp = hp_q + 6'd1;

   always_comb begin
      state_d  = state_q;
      hp_d     = hp_q;
      gap_d    = gap_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      cmd_d    = cmd_q;
      shreg_d  = shreg_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
`ifdef ADC_SPI_SAMPLER_AVG_EN
      acc_d    = acc_q;
      grp_d    = grp_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef ADC_SPI_SAMPLER_AVG_EN
            acc_d = '0;
            grp_d = '0;
`endif
            if (en) begin
               state_d = SETUP;
               cmd_d   = build_cmd(channel);
               mosi_d  = 1'b1;
               sclk_d  = 1'b0;
            end
         end
         SETUP: begin
            if (half_tick) begin
               state_d = SHIFT;
               hp_d    = '0;
               sclk_d  = 1'b1;
            end
         end
         SHIFT: begin
            if (half_tick) begin
               if (hp_q == 6'(SHIFT_HALF_PERIODS - 1)) begin
                  state_d = HOLD;
                  sclk_d  = 1'b0;
               end else begin
                  hp_d   = next_hp;
                  sclk_d = ~sclk_q;
                  if (!next_hp[0]) begin
                     if (next_hp[5:1] >= 5'(FIRST_DATA_EDGE) && next_hp[5:1] <= 5'(LAST_EDGE)) begin
                        shreg_d = {shreg_q[SAMPLE_W-2:0], miso};
                     end
                  end else begin
                     // Command shifts out on falling edges; zeros fill in once it is exhausted
                     mosi_d = cmd_q[CMD_BITS-2];
                     cmd_d  = {cmd_q[CMD_BITS-2:0], 1'b0};
                  end
               end
            end
         end
         HOLD: begin
            if (half_tick) begin
               state_d = GAP;
               gap_d   = '0;
               sclk_d  = 1'b0;
`ifdef ADC_SPI_SAMPLER_AVG_EN
               if (grp_q == 2'd3) begin
                  sample_d = avg_sum[SAMPLE_W+1:2];
                  valid_d  = 1'b1;
                  acc_d    = '0;
                  grp_d    = '0;
               end else begin
                  acc_d = avg_sum;
                  grp_d = grp_q + 2'd1;
               end
`else
               sample_d = shreg_q;
               valid_d  = 1'b1;
`endif
            end
         end
         GAP: begin
            if (half_tick) begin
               if (gap_q == 8'(SAMPLE_GAP - 1)) begin
                  if (en) begin
                     state_d = SETUP;
                     cmd_d   = build_cmd(channel);
                     mosi_d  = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  gap_d = gap_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         hp_q     <= '0;
         gap_q    <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         cmd_q    <= '0;
         shreg_q  <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
`ifdef ADC_SPI_SAMPLER_AVG_EN
         acc_q    <= '0;
         grp_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         hp_q     <= hp_d;
         gap_q    <= gap_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         cmd_q    <= cmd_d;
         shreg_q  <= shreg_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
`ifdef ADC_SPI_SAMPLER_AVG_EN
         acc_q    <= acc_d;
         grp_q    <= grp_d;
`endif
      end
   end

   // Decoded from state so an asynchronous reset releases the ADC at once
   assign busy         = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
   assign cs_n         = !busy;
   assign sclk         = sclk_q;
   assign mosi         = mosi_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb/tb_adc_spi_sampler.sv - directed bench with an MCP3204 model; define ADC_SPI_SAMPLER_AVG_EN for the averaging case
module tb_adc_spi_sampler;

   localparam int CLK_DIV    = 2;
   localparam int SAMPLE_GAP = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  channel = 2'b01;
   logic        miso = 1'b0;
   logic        cs_n, sclk, mosi, sample_valid, busy;
   logic [11:0] sample;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   adc_spi_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_GAP(SAMPLE_GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .channel      (channel),
      .miso         (miso),
      .cs_n         (cs_n),
      .sclk         (sclk),
      .mosi         (mosi),
      .sample       (sample),
      .sample_valid (sample_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ADC model and frame observer
   logic [11:0] data_q[$];
   logic [11:0] cur_data = 12'h000;
   logic [11:0] strobe_sample = 12'h000;
   logic [4:0]  mosi_bits = 5'd0;
   logic [4:0]  mosi_last = 5'd0;
   logic        prev_sclk = 1'b0;
   logic        prev_cs = 1'b1;
   logic        prev_sv = 1'b0;
   logic        strobe_cs_ok = 1'b0;
   int rises = 0, total_rises = 0, csl = 0, csl_last = 0, rises_last = 0;
   int gap_cnt = 0, gap_last = 0, frames = 0, strobes = 0, strobe_frames = 0;
   int last_strobe_cyc = 0, prev_strobe_cyc = 0, double_strobe = 0;

   always @(negedge clk) begin
      if (prev_cs && !cs_n) begin
         rises     = 0;
         frames++;
         gap_last  = gap_cnt;
         csl       = 0;
         mosi_bits = 5'd0;
         if (data_q.size() > 0) cur_data = data_q.pop_front();
         miso      = 1'b0;
      end
      if (!cs_n) csl++;
      else gap_cnt = prev_cs ? gap_cnt + 1 : 1;
      if (!prev_sclk && sclk) begin
         if (rises < 5) mosi_bits[4-rises] = mosi;
         rises++;
         total_rises++;
      end
      if (prev_sclk && !sclk) begin
         miso = (rises >= 7 && rises <= 18) ? cur_data[18-rises] : 1'b0;
      end
      if (sample_valid) begin
         if (prev_sv) double_strobe++;
         strobes++;
         prev_strobe_cyc = last_strobe_cyc;
         last_strobe_cyc = cyc;
         strobe_sample   = sample;
         strobe_cs_ok    = cs_n && !prev_cs;
         csl_last        = csl;
         rises_last      = rises;
         mosi_last       = mosi_bits;
         strobe_frames   = frames;
      end
      prev_sv   = sample_valid;
      prev_sclk = sclk;
      prev_cs   = cs_n;
   end

   task automatic wait_strobes(input int n, input int budget);
      int i = 0;
      while (strobes < n && i < budget) begin
         @(negedge clk); #1;
         i++;
      end
      if (strobes < n) check("strobe_timeout", strobes, n);
   endtask

   task automatic wait_frame_rise(input int f, input int k, input int budget);
      int i = 0;
      while (!(frames >= f && rises >= k && !cs_n) && i < budget) begin
         @(negedge clk); #1;
         i++;
      end
      if (i >= budget) check("rise_timeout", rises, k);
   endtask

   initial begin
      int s;
      int t;
      repeat (3) @(negedge clk);
      #1;
      check("rst_cs_n", cs_n, 1);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_sample", sample, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;
`ifdef ADC_SPI_SAMPLER_AVG_EN
      data_q.push_back(12'd100);
      data_q.push_back(12'd101);
      data_q.push_back(12'd102);
      data_q.push_back(12'd104);
      en = 1'b1;
      wait_strobes(1, 4 * 88 + 200);
      check("avg_strobe_frame", strobe_frames, 4);
      check("avg_sample", strobe_sample, 12'd101);
      check("avg_single_strobe", double_strobe, 0);
`else
      data_q.push_back(12'hA5C);
      data_q.push_back(12'h001);
      data_q.push_back(12'hFFF);
      data_q.push_back(12'h3C5);
      en = 1'b1;
      wait_strobes(1, 300);
      check("f1_cmd", mosi_last, 5'b11001);
      check("f1_rises", rises_last, 19);
      check("f1_cs_low", csl_last, 80);
      check("f1_sample", strobe_sample, 12'hA5C);
      check("f1_strobe_at_cs_rise", strobe_cs_ok, 1);
      wait_frame_rise(2, 2, 300);
      channel = 2'b10;
      wait_strobes(2, 300);
      check("f2_cmd_unchanged", mosi_last, 5'b11001);
      check("f2_sample", strobe_sample, 12'h001);
      check("f2_period", last_strobe_cyc - prev_strobe_cyc, 88);
      wait_strobes(3, 300);
      check("f3_cmd", mosi_last, 5'b11010);
      check("f3_sample", strobe_sample, 12'hFFF);
      check("f3_period", last_strobe_cyc - prev_strobe_cyc, 88);
      check("f3_gap", gap_last, 8);
      wait_frame_rise(4, 11, 300);
      en = 1'b0;
      wait_strobes(4, 300);
      check("f4_sample", strobe_sample, 12'h3C5);
      check("f4_held", sample, 12'h3C5);
      t = total_rises;
      repeat (300) @(negedge clk);
      #1;
      check("idle_no_sclk", total_rises, t);
      check("idle_cs_n", cs_n, 1);
      check("idle_busy", busy, 0);
      check("idle_strobes", strobes, 4);
      data_q.push_back(12'h5A5);
      data_q.push_back(12'h777);
      en = 1'b1;
      wait_frame_rise(5, 13, 400);
      s = strobes;
      rst = 1'b0;
      #1;
      check("abort_cs_n", cs_n, 1);
      check("abort_sclk", sclk, 0);
      check("abort_sample", sample, 0);
      check("abort_valid", sample_valid, 0);
      repeat (4) @(negedge clk);
      #1;
      check("abort_no_strobe", strobes, s);
      rst = 1'b1;
      wait_strobes(s + 1, 300);
      check("after_abort_cs_low", csl_last, 80);
      check("after_abort_rises", rises_last, 19);
      check("after_abort_sample", strobe_sample, 12'h777);
      check("single_clk_strobes", double_strobe, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
